// File: rtl/instr_identify_pipe_if.sv
// Instruction stream bundle: fetch-side word handshake, flush control and
// the decoded-instruction FIFO head presented to decode/branch units.
// The slave modport is the identify pipe; the master modport is its environment.
interface instr_identify_pipe_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              i_flush;
  logic [ADDR_W-1:0] i_flush_addr;
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_word;
  logic              o_valid;
  logic              i_ready;
  logic [63:0]       o_instr;
  logic [ADDR_W-1:0] o_addr;
  logic              o_is_prefixed;
  logic              o_is_branch;
  logic              o_misalign;
  logic [CW-1:0]     o_count;

  modport slave (
    input  i_flush, i_flush_addr, i_valid, i_word, i_ready,
    output o_ready, o_valid, o_instr, o_addr, o_is_prefixed, o_is_branch,
           o_misalign, o_count
  );

  modport master (
    output i_flush, i_flush_addr, i_valid, i_word, i_ready,
    input  o_ready, o_valid, o_instr, o_addr, o_is_prefixed, o_is_branch,
           o_misalign, o_count
  );
endinterface

// File: rtl/instr_identify_pipe.sv
// Pairs Power ISA prefixes with suffixes, tags address/branch/misalign, queues results.
// Latency: entry visible at FIFO head the cycle after its last word is accepted.
// Backpressure: o_ready drops while the FIFO is full or flushing; a pending prefix waits.
module instr_identify_pipe #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  instr_identify_pipe_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [63:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              prefixed;
    logic              branch;
    logic              misalign;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  // ISA numbers bits MSB-first from index 0, so fields are read bit-reversed.
  function automatic logic [5:0] f_op(input logic [31:0] w);
    return {w[0], w[1], w[2], w[3], w[4], w[5]};
  endfunction

  function automatic logic [9:0] f_xo(input logic [31:0] w);
    return {w[21], w[22], w[23], w[24], w[25], w[26], w[27], w[28], w[29], w[30]};
  endfunction

  // b, bc, and the XL-form register branches bclr/bcctr/bctar.
  function automatic logic f_branch(input logic [31:0] w);
    logic [5:0] op;
    logic [9:0] xo;
    op = f_op(w);
    xo = f_xo(w);
    return (op == 6'd18) || (op == 6'd16) ||
           ((op == 6'd19) && ((xo == 10'd16) || (xo == 10'd528) || (xo == 10'd560)));
  endfunction

  state_t            state_q, state_d;
  entry_t            mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       pend_word;
  logic [ADDR_W-1:0] pend_addr;
  logic              accept, pop, push, store_prefix, word_is_prefix;
  entry_t            push_entry;
  entry_t            head;

  assign bus.o_ready    = i_rst && !bus.i_flush && (count < FULL);
  assign accept         = bus.i_valid && bus.o_ready;
  assign pop            = (count != '0) && bus.i_ready && !bus.i_flush;
  assign word_is_prefix = (bus.i_word[5:0] == 6'b100000);

  // Next state and the entry to enqueue; the suffix is taken whatever its opcode.
  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    store_prefix = 1'b0;
    push_entry   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (word_is_prefix) begin
            store_prefix = 1'b1;
            state_d      = PEND;
          end else begin
            push              = 1'b1;
            push_entry.instr  = {32'h0, bus.i_word};
            push_entry.addr   = addr_q;
            push_entry.branch = f_branch(bus.i_word);
          end
        end
      end
      PEND: begin
        if (accept) begin
          push                = 1'b1;
          push_entry.instr    = {bus.i_word, pend_word};
          push_entry.addr     = pend_addr;
          push_entry.prefixed = 1'b1;
          push_entry.branch   = f_branch(bus.i_word);
          push_entry.misalign = (pend_addr[5:2] == 4'b1111);
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) state_d = IDLE;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Word address counter and held prefix; flush reloads a word-aligned address.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_q    <= '0;
      pend_word <= '0;
      pend_addr <= '0;
    end else if (bus.i_flush) begin
      addr_q    <= bus.i_flush_addr & ~ADDR_W'(3);
      pend_word <= '0;
      pend_addr <= '0;
    end else begin
      if (accept) addr_q <= addr_q + ADDR_W'(4);
      if (store_prefix) begin
        pend_word <= bus.i_word;
        pend_addr <= addr_q;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Head is forced to zero when the FIFO is empty.
  assign head              = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.o_valid       = (count != '0);
  assign bus.o_count       = count;
  assign bus.o_instr       = head.instr;
  assign bus.o_addr        = head.addr;
  assign bus.o_is_prefixed = head.prefixed;
  assign bus.o_is_branch   = head.branch;
  assign bus.o_misalign    = head.misalign;
endmodule

// File: tb/tb_instr_identify_pipe.sv
// Bench for instr_identify_pipe: vector table, corner sequences and a
// randomized stream compared against a queue-based reference model.
module tb_instr_identify_pipe;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  localparam logic [31:0] F = 32'h5A5A_A5A5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_identify_pipe_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();
  instr_identify_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Build a word from ISA fields: ISA bit k lives at index k, MSB-first.
  function automatic logic [31:0] mkw(input int op, input int xo, input logic [31:0] fill);
    logic [31:0] w;
    w = fill;
    for (int k = 0; k < 6; k++)   w[k] = op[5-k];
    for (int k = 21; k <= 30; k++) w[k] = xo[30-k];
    return w;
  endfunction

  function automatic int ref_op(input logic [31:0] w);
    int v = 0;
    for (int k = 0; k < 6; k++) v = v * 2 + int'(w[k]);
    return v;
  endfunction

  function automatic int ref_xo(input logic [31:0] w);
    int v = 0;
    for (int k = 21; k <= 30; k++) v = v * 2 + int'(w[k]);
    return v;
  endfunction

  function automatic logic ref_branch(input logic [31:0] w);
    int op = ref_op(w);
    int xo = ref_xo(w);
    return (op == 18) || (op == 16) || (op == 19 && (xo == 16 || xo == 528 || xo == 560));
  endfunction

  // Reference model: an ordered list of expected entries plus the pairing state.
  typedef struct {
    logic [63:0] instr;
    logic [63:0] addr;
    logic        pf;
    logic        br;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  logic        m_pend;
  logic [31:0] m_pword;
  logic [63:0] m_paddr;
  logic [63:0] m_addr;

  task automatic model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_pword = '0;
    m_paddr = '0;
    m_addr = '0;
  endtask

  // One clock: drive at negedge, compare against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] w, input logic rdy,
                      input logic fl, input logic [63:0] fa);
    logic mr;
    ent_t e;
    ent_t n;
    @(negedge clk);
    bus.i_valid      = v;
    bus.i_word       = w;
    bus.i_ready      = rdy;
    bus.i_flush      = fl;
    bus.i_flush_addr = fa;
    #1;
    mr = !fl && (mq.size() < DEPTH);
    if (mq.size() != 0) e = mq[0];
    else e = '{instr: 64'h0, addr: 64'h0, pf: 1'b0, br: 1'b0, mis: 1'b0};
    check("m_ready", bus.o_ready, mr);
    check("m_count", bus.o_count, mq.size());
    check("m_valid", bus.o_valid, mq.size() != 0);
    check("m_instr", bus.o_instr, e.instr);
    check("m_addr", bus.o_addr, e.addr);
    check("m_flags", {bus.o_is_prefixed, bus.o_is_branch, bus.o_misalign}, {e.pf, e.br, e.mis});
    if (fl) begin
      mq.delete();
      m_pend = 1'b0;
      m_addr = fa & ~64'h3;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (v && mr) begin
        if (m_pend) begin
          n = '{instr: {w, m_pword}, addr: m_paddr, pf: 1'b1, br: ref_branch(w),
                mis: (m_paddr % 64) == 60};
          mq.push_back(n);
          m_pend = 1'b0;
        end else if (ref_op(w) == 1) begin
          m_pend  = 1'b1;
          m_pword = w;
          m_paddr = m_addr;
        end else begin
          n = '{instr: {32'h0, w}, addr: m_addr, pf: 1'b0, br: ref_branch(w), mis: 1'b0};
          mq.push_back(n);
        end
        m_addr = m_addr + 64'd4;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    int sel = $urandom_range(0, 7);
    int xs  = $urandom_range(0, 4);
    int xo;
    case (xs)
      0: xo = 16;
      1: xo = 528;
      2: xo = 560;
      3: xo = 0;
      default: xo = 17;
    endcase
    case (sel)
      0, 1: return mkw(1, 0, $urandom);
      2:    return mkw(18, 0, $urandom);
      3:    return mkw(16, 0, $urandom);
      4:    return mkw(19, xo, $urandom);
      5:    return mkw(31, 266, $urandom);
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [63:0] start;
    logic        pf;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp_addr;
    logic        exp_br;
    logic        exp_mis;
  } vec_t;

  vec_t vt[15];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [63:0] exp_instr;

    vt[0]  = '{64'h1000, 1'b0, mkw(18, 0, F),    32'h0,           64'h1000, 1'b1, 1'b0};
    vt[1]  = '{64'h1100, 1'b0, mkw(16, 0, F),    32'h0,           64'h1100, 1'b1, 1'b0};
    vt[2]  = '{64'h1200, 1'b0, mkw(19, 16, F),   32'h0,           64'h1200, 1'b1, 1'b0};
    vt[3]  = '{64'h1300, 1'b0, mkw(19, 528, F),  32'h0,           64'h1300, 1'b1, 1'b0};
    vt[4]  = '{64'h1400, 1'b0, mkw(19, 560, F),  32'h0,           64'h1400, 1'b1, 1'b0};
    vt[5]  = '{64'h1500, 1'b0, mkw(19, 0, F),    32'h0,           64'h1500, 1'b0, 1'b0};
    vt[6]  = '{64'h1600, 1'b0, mkw(19, 17, F),   32'h0,           64'h1600, 1'b0, 1'b0};
    vt[7]  = '{64'h1700, 1'b0, mkw(31, 266, F),  32'h0,           64'h1700, 1'b0, 1'b0};
    vt[8]  = '{64'h2000, 1'b1, mkw(1, 0, F),     mkw(14, 0, F),   64'h2000, 1'b0, 1'b0};
    vt[9]  = '{64'h203C, 1'b1, mkw(1, 0, F),     mkw(14, 0, F),   64'h203C, 1'b0, 1'b1};
    vt[10] = '{64'h2038, 1'b1, mkw(1, 0, F),     mkw(14, 0, F),   64'h2038, 1'b0, 1'b0};
    vt[11] = '{64'h2100, 1'b1, mkw(1, 0, F),     mkw(19, 528, F), 64'h2100, 1'b1, 1'b0};
    vt[12] = '{64'h3003, 1'b1, mkw(1, 0, F),     mkw(1, 0, 32'h1234_5678), 64'h3000, 1'b0, 1'b0};
    vt[13] = '{64'h1FFC, 1'b1, mkw(1, 0, F),     mkw(18, 0, F),   64'h1FFC, 1'b1, 1'b1};
    vt[14] = '{64'h403C, 1'b0, mkw(31, 0, F),    32'h0,           64'h403C, 1'b0, 1'b0};

    bus.i_valid = 1'b0; bus.i_word = '0; bus.i_ready = 1'b0;
    bus.i_flush = 1'b0; bus.i_flush_addr = '0;
    model_reset();

    // Reset state.
    #12;
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_count", bus.o_count, 0);
    check("rst_ready", bus.o_ready, 1'b0);
    check("rst_instr", bus.o_instr, 64'h0);
    check("rst_addr", bus.o_addr, 64'h0);
    check("rst_flags", {bus.o_is_prefixed, bus.o_is_branch, bus.o_misalign}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", bus.o_ready, 1'b1);

    // Vector table: one instruction per record, visible the cycle after acceptance.
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, vt[i].start);
      if (vt[i].pf) step(1'b1, vt[i].w0, 1'b0, 1'b0, 64'h0);
      step(1'b1, vt[i].pf ? vt[i].w1 : vt[i].w0, 1'b0, 1'b0, 64'h0);
      after_edge();
      exp_instr = vt[i].pf ? {vt[i].w1, vt[i].w0} : {32'h0, vt[i].w0};
      check($sformatf("vec%0d_valid", i), bus.o_valid, 1'b1);
      check($sformatf("vec%0d_count", i), bus.o_count, 1);
      check($sformatf("vec%0d_instr", i), bus.o_instr, exp_instr);
      check($sformatf("vec%0d_addr", i), bus.o_addr, vt[i].exp_addr);
      check($sformatf("vec%0d_pf", i), bus.o_is_prefixed, vt[i].pf);
      check($sformatf("vec%0d_br", i), bus.o_is_branch, vt[i].exp_br);
      check($sformatf("vec%0d_mis", i), bus.o_misalign, vt[i].exp_mis);
      step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    end
    idle();

    // b then add from 0x1000.
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'h1000);
    step(1'b1, mkw(18, 0, F), 1'b0, 1'b0, 64'h0);
    after_edge();
    check("seq_b_valid", bus.o_valid, 1'b1);
    check("seq_b_br", bus.o_is_branch, 1'b1);
    check("seq_b_addr", bus.o_addr, 64'h1000);
    step(1'b1, mkw(31, 266, F), 1'b1, 1'b0, 64'h0);
    after_edge();
    check("seq_add_count", bus.o_count, 1);
    check("seq_add_instr", bus.o_instr, {32'h0, mkw(31, 266, F)});
    check("seq_add_br", bus.o_is_branch, 1'b0);
    check("seq_add_addr", bus.o_addr, 64'h1004);
    step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);

    // Address after a pair advances by 8.
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'h2000);
    step(1'b1, mkw(1, 0, F), 1'b0, 1'b0, 64'h0);
    step(1'b1, mkw(14, 0, F), 1'b0, 1'b0, 64'h0);
    step(1'b1, mkw(31, 266, F), 1'b0, 1'b0, 64'h0);
    after_edge();
    check("pair_addr", bus.o_addr, 64'h2000);
    step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    after_edge();
    check("next_addr", bus.o_addr, 64'h2008);
    check("next_pf", bus.o_is_prefixed, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);

    // Full FIFO with the suffix completing the fill, then a stalled extra word.
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'h4000);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, mkw(31, i, F), 1'b0, 1'b0, 64'h0);
    step(1'b1, mkw(1, 0, F), 1'b0, 1'b0, 64'h0);
    after_edge();
    check("full_pend_count", bus.o_count, DEPTH - 1);
    step(1'b1, mkw(16, 0, F), 1'b0, 1'b0, 64'h0);
    after_edge();
    check("full_count", bus.o_count, DEPTH);
    check("full_ready", bus.o_ready, 1'b0);
    repeat (3) step(1'b1, mkw(18, 0, F), 1'b0, 1'b0, 64'h0);
    after_edge();
    check("stall_count", bus.o_count, DEPTH);
    step(1'b1, mkw(18, 0, F), 1'b1, 1'b0, 64'h0);
    after_edge();
    check("pop_full_count", bus.o_count, DEPTH - 1);
    step(1'b1, mkw(18, 0, F), 1'b1, 1'b0, 64'h0);
    after_edge();
    check("pushpop_count", bus.o_count, DEPTH - 1);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    after_edge();
    check("drain_count", bus.o_count, 0);

    // Flush while a prefix is pending and the FIFO holds an entry.
    step(1'b0, 32'h0, 1'b0, 1'b1, 64'h5000);
    step(1'b1, mkw(31, 0, F), 1'b0, 1'b0, 64'h0);
    step(1'b1, mkw(1, 0, F), 1'b0, 1'b0, 64'h0);
    step(1'b1, mkw(14, 0, F), 1'b1, 1'b1, 64'h3000);
    after_edge();
    check("flush_count", bus.o_count, 0);
    check("flush_valid", bus.o_valid, 1'b0);
    step(1'b1, mkw(31, 266, F), 1'b0, 1'b0, 64'h0);
    after_edge();
    check("flush_next_count", bus.o_count, 1);
    check("flush_next_addr", bus.o_addr, 64'h3000);
    check("flush_next_pf", bus.o_is_prefixed, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);

    // Randomized stream against the model.
    for (int i = 0; i < 600; i++) begin
      logic fl;
      logic [63:0] fa;
      fl = ($urandom_range(0, 99) < 3);
      fa = {32'h0, $urandom} | (($urandom_range(0, 1) == 1) ? 64'h3C : 64'h0);
      w  = rand_word();
      step($urandom_range(0, 99) < 70, w, $urandom_range(0, 99) < 60, fl, fa);
    end

    // Reset in the middle of traffic.
    repeat (5) step(1'b1, rand_word(), 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check("mid_rst_valid", bus.o_valid, 1'b0);
    check("mid_rst_count", bus.o_count, 0);
    check("mid_rst_ready", bus.o_ready, 1'b0);
    check("mid_rst_instr", bus.o_instr, 64'h0);
    check("mid_rst_addr", bus.o_addr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, mkw(31, 266, F), 1'b0, 1'b0, 64'h0);
    after_edge();
    check("post_rst_addr", bus.o_addr, 64'h0);
    check("post_rst_count", bus.o_count, 1);
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 99) < 70, rand_word(), $urandom_range(0, 99) < 50, 1'b0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
